wb_trace_buf: RTL and testbench

WB_TRACE_BUF -- requirements
Module: wb_trace_buf

---
 rtl/wb_trace_buf.sv | 119 +++++++++++
 tb/tb_wb_trace_buf.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buf.sv
// wb_trace_buf: write-back trace FIFO for a CPU debug port.
//
// Each cycle where WB writes a non-zero register, the retiring PC and the
// register write are packed into one 73-bit entry and pushed into a
// DEPTH-entry first-word-fall-through FIFO. When the FIFO is full and the
// head is not popped in the same cycle, the entry is dropped. A sticky
// overflow flag and a saturating counter record every drop.
//
// Ports:
//   clk                sole clock, rising edge
//   reset              asynchronous, active-high reset
//   debug_wb_pc        PC of the retiring instruction
//   debug_wb_rf_wen    register-file byte write enables
//   debug_wb_rf_wnum   destination register number
//   debug_wb_rf_wdata  write-back data
//   trace_clr          synchronous flush of buffer and statistics
//   trace_valid        head entry available
//   trace_ready        consumer accepts the head entry
//   trace_data         head entry {pc, wen, wnum, wdata}
//   trace_count        current occupancy
//   trace_overflow     sticky: at least one entry dropped
//   trace_drop_cnt     saturating count of dropped entries
module wb_trace_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     trace_clr,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [72:0]              trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     trace_overflow,
  output logic [CNT_W-1:0]         trace_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [72:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic        capture, pop, push, drop, full;
  logic [72:0] entry;

  assign entry   = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
  assign capture = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign full    = (count_q == FullCount);
  assign pop     = trace_valid && trace_ready && !trace_clr;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push    = capture && !trace_clr && (!full || pop);
  assign drop    = capture && !trace_clr && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (trace_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= entry;
  end

  assign trace_valid    = (count_q != '0);
  assign trace_data     = mem_q[rd_ptr_q];
  assign trace_count    = count_q;
  assign trace_overflow = overflow_q;
  assign trace_drop_cnt = drop_q;

endmodule

// File: tb/tb_wb_trace_buf.sv
module tb_wb_trace_buf;

  localparam int unsigned DEPTH = 16;
  // Narrow drop counter so saturation is reachable in a short run.
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [3:0]  wen;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic        clr;
  logic        ready;
  logic        trace_valid;
  logic [72:0] trace_data;
  logic [4:0]  trace_count;
  logic        trace_overflow;
  logic [CNT_W-1:0] trace_drop_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of entries plus the two statistics.
  logic [72:0] q[$];
  logic        m_ovf;
  int unsigned m_drops;

  wb_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .debug_wb_pc      (pc),
    .debug_wb_rf_wen  (wen),
    .debug_wb_rf_wnum (wnum),
    .debug_wb_rf_wdata(wdata),
    .trace_clr        (clr),
    .trace_valid      (trace_valid),
    .trace_ready      (ready),
    .trace_data       (trace_data),
    .trace_count      (trace_count),
    .trace_overflow   (trace_overflow),
    .trace_drop_cnt   (trace_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check(input string tag);
    tests++;
    assert (trace_valid === (q.size() != 0))
    else begin fails++; $error("FAIL %s valid: got %b exp %b", tag, trace_valid, q.size() != 0); end
    tests++;
    assert (trace_count === 5'(q.size()))
    else begin fails++; $error("FAIL %s count: got %0d exp %0d", tag, trace_count, q.size()); end
    tests++;
    assert (trace_overflow === m_ovf)
    else begin fails++; $error("FAIL %s overflow: got %b exp %b", tag, trace_overflow, m_ovf); end
    tests++;
    assert (trace_drop_cnt === CNT_W'(m_drops))
    else begin fails++; $error("FAIL %s drops: got %0d exp %0d", tag, trace_drop_cnt, m_drops); end
    if (q.size() != 0) begin
      tests++;
      assert (trace_data === q[0])
      else begin fails++; $error("FAIL %s data: got %h exp %h", tag, trace_data, q[0]); end
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, check after the edge.
  task automatic cycle(input logic [31:0] p, input logic [3:0] w, input logic [4:0] n,
                       input logic [31:0] d, input logic rdy, input logic c, input string tag);
    logic        cap;
    logic [72:0] junk;
    pc = p; wen = w; wnum = n; wdata = d; ready = rdy; clr = c;
    cap = (w != 0) && (n != 0);
    if (c) begin
      model_clear();
    end else begin
      if (rdy && q.size() != 0) junk = q.pop_front();
      if (cap) begin
        if (q.size() < DEPTH) q.push_back({p, w, n, d});
        else begin
          m_ovf = 1'b1;
          if (m_drops < DROP_MAX) m_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic rand_cap(input logic rdy, input string tag);
    cycle($urandom, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)), $urandom, rdy, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1;
    pc = '0; wen = '0; wnum = '0; wdata = '0; clr = 1'b0; ready = 1'b0;
    model_clear();
    #1;
    check("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single capture becomes visible the next cycle.
    cycle(32'hBFC0_0000, 4'hF, 5'd2, 32'h1234, 1'b0, 1'b0, "first_cap");
    cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, "clr1");

    // No-write and $0 writes are never stored.
    cycle(32'h100, 4'h0, 5'd7, 32'hAAAA, 1'b0, 1'b0, "wen0");
    cycle(32'h104, 4'hF, 5'd0, 32'hBBBB, 1'b0, 1'b0, "wnum0");
    cycle(32'h108, 4'h0, 5'd0, 32'hCCCC, 1'b1, 1'b0, "ready_empty");

    // 17 captures: 16 stored, 1 dropped.
    for (int i = 0; i < 17; i++) rand_cap(1'b0, "fill17");
    // Full plus pop plus capture: count stays, no new drop.
    rand_cap(1'b1, "full_pushpop");
    // Stall with valid head: data must hold.
    cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0, "stall");
    for (int i = 0; i < 16; i++) cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, "drain");
    cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, "drained");

    // Overfill to saturate the drop counter, then clear alongside a capture.
    for (int i = 0; i < DEPTH + DROP_MAX + 3; i++) rand_cap(1'b0, "sat");
    rand_cap(1'b1, "sat_pushpop");
    cycle(32'h200, 4'h3, 5'd9, 32'h55, 1'b1, 1'b1, "clr_cap");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] w;
      logic [4:0] n;
      w = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
      n = ($urandom_range(0, 9) < 1) ? 5'd0 : 5'($urandom);
      cycle($urandom, w, n, $urandom, 1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 59) == 0), "random");
    end

    // Reset in the middle of a drain with five entries held.
    cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 7; i++) rand_cap(1'b0, "pre_rst");
    for (int i = 0; i < 2; i++) cycle(32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, "pre_rst_drain");
    ready = 1'b1;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_rst");
    pc = 32'h300; wen = 4'hF; wnum = 5'd4; wdata = 32'h77;
    @(posedge clk);
    #1;
    check("rst_held_cap");
    @(negedge clk);
    reset = 1'b0;
    cycle(32'h304, 4'h1, 5'd5, 32'h99, 1'b0, 1'b0, "post_rst_cap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
